// File: rtl/rr_mux_arbiter4_if.sv
// Requester/resource-side signal bundle of the four-way round-robin arbiter.
// The master modport is the arbiter; the slave modport is the requester/resource side.
interface rr_mux_arbiter4_if #(
   parameter int unsigned CNT_W = 8
);
   logic [3:0]       req;
   logic             ack;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic             valid;
   logic             timeout_err;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      input  req,
      input  ack,
      output gnt,
      output sel,
      output valid,
      output timeout_err,
      output hold_cnt
   );

   modport slave (
      output req,
      output ack,
      input  gnt,
      input  sel,
      input  valid,
      input  timeout_err,
      input  hold_cnt
   );
endinterface

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter granting one shared 32-bit port to four requesters.
// It also drives the 2-bit select of the data mux in front of that port.
module rr_mux_arbiter4 #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input logic                clk,
   input logic                rst,
   rr_mux_arbiter4_if.master  arb_io
);

   localparam logic             TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             terr_q, terr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [1:0]       ptr_q, ptr_d;

   logic             owner_req;
   logic             tmo_hit;
   logic             end_grant;
   logic [3:0]       excl_mask;
   pick_t            win;

   // First requester at or after start, wrapping mod 4.
   function automatic pick_t pick(input logic [3:0] r, input logic [1:0] start);
      pick_t      res;
      logic [1:0] idx;
      res = '0;
      for (int k = 0; k < 4; k++) begin
         idx = start + 2'(k);
         if (!res.found && r[idx]) begin
            res.found = 1'b1;
            res.idx   = idx;
         end
      end
      return res;
   endfunction

   assign owner_req = arb_io.req[sel_q];
   assign tmo_hit   = TO_EN && (hold_q == TO_LAST);
   assign end_grant = arb_io.ack | ~owner_req | tmo_hit;
   // The ending owner sits out the handoff scan for this edge only.
   assign excl_mask = (state_q == BUSY) ? (4'b0001 << sel_q) : 4'b0000;
   assign win       = pick(arb_io.req & ~excl_mask, ptr_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      terr_d  = 1'b0;
      hold_d  = hold_q;
      ptr_d   = ptr_q;

      case (state_q)
         IDLE: begin
            if (win.found) begin
               state_d = BUSY;
               gnt_d   = 4'b0001 << win.idx;
               sel_d   = win.idx;
               valid_d = 1'b1;
               hold_d  = '0;
               ptr_d   = win.idx + 2'd1;
            end
         end
         BUSY: begin
            if (end_grant) begin
               // Only a grant that neither completed nor was withdrawn counts as revoked.
               terr_d = ~arb_io.ack & owner_req & tmo_hit;
               if (win.found) begin
                  gnt_d   = 4'b0001 << win.idx;
                  sel_d   = win.idx;
                  valid_d = 1'b1;
                  hold_d  = '0;
                  ptr_d   = win.idx + 2'd1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  valid_d = 1'b0;
                  hold_d  = '0;
               end
            end else if (hold_q != '1) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         terr_q  <= 1'b0;
         hold_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         terr_q  <= terr_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
      end
   end

   assign arb_io.gnt         = gnt_q;
   assign arb_io.sel         = sel_q;
   assign arb_io.valid       = valid_q;
   assign arb_io.timeout_err = terr_q;
   assign arb_io.hold_cnt    = hold_q;

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Directed bench for rr_mux_arbiter4 with a cycle-level reference model and literal spot checks.
module tb_rr_mux_arbiter4;

   localparam int unsigned TIMEOUT  = 16;
   localparam int unsigned CNT_W    = 8;
   localparam int          HOLD_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst;

   rr_mux_arbiter4_if #(.CNT_W(CNT_W)) bus_if ();

   rr_mux_arbiter4 #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_io (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 when idle), rotating start pointer, elapsed-cycle count.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   int m_sel   = 0;
   bit m_to    = 1'b0;
   bit m_live  = 1'b0;
   int m_w;
   bit m_tmo;

   function automatic int find_win(input logic [3:0] r, input int start, input int excl);
      int i;
      for (int k = 0; k < 4; k++) begin
         i = (start + k) % 4;
         if (i != excl && r[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_to = 1'b0; m_live = 1'b1;
      end else begin
         m_to = 1'b0;
         if (m_owner < 0) begin
            m_w = find_win(bus_if.req, m_ptr, -1);
            if (m_w >= 0) begin
               m_owner = m_w; m_hold = 0; m_ptr = (m_w + 1) % 4; m_sel = m_w;
            end
         end else begin
            m_tmo = (TIMEOUT > 0) && (m_hold == int'(TIMEOUT) - 1);
            if (bus_if.ack || !bus_if.req[m_owner] || m_tmo) begin
               m_to = !bus_if.ack && bus_if.req[m_owner] && m_tmo;
               m_w  = find_win(bus_if.req, m_ptr, m_owner);
               if (m_w >= 0) begin
                  m_owner = m_w; m_hold = 0; m_ptr = (m_w + 1) % 4; m_sel = m_w;
               end else begin
                  m_owner = -1; m_hold = 0;
               end
            end else if (m_hold < HOLD_MAX) begin
               m_hold++;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("m_gnt",   32'(bus_if.gnt),   (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
         chk("m_valid", 32'(bus_if.valid), (m_owner < 0) ? 32'd0 : 32'd1);
         chk("m_sel",   32'(bus_if.sel),   32'(m_sel));
         chk("m_terr",  32'(bus_if.timeout_err), 32'(m_to));
         if (m_owner >= 0) chk("m_hold", 32'(bus_if.hold_cnt), 32'(m_hold));
      end
   end

   // Apply inputs for the next rising edge; on return the outputs of the previous edge are visible.
   task automatic cyc(input logic [3:0] r, input logic a, input logic rs);
      @(negedge clk);
      bus_if.req = r;
      bus_if.ack = a;
      rst        = rs;
   endtask

   int order[$];
   int exp_order[5] = '{0, 1, 2, 3, 0};
   int gaps;
   int maxh;
   int pulses;
   int revoke_idle;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; bus_if.req = '0; bus_if.ack = 1'b0;
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b0000, 1'b0, 1'b1);

      // Single request, grant, ack
      cyc(4'b0001, 1'b0, 1'b0);
      chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
      chk("rst_sel", 32'(bus_if.sel), 32'd0);
      chk("rst_valid", 32'(bus_if.valid), 32'd0);
      chk("rst_hold", 32'(bus_if.hold_cnt), 32'd0);
      chk("rst_terr", 32'(bus_if.timeout_err), 32'd0);
      cyc(4'b0001, 1'b1, 1'b0);
      chk("t1_gnt", 32'(bus_if.gnt), 32'h1);
      chk("t1_valid", 32'(bus_if.valid), 32'd1);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t1_idle_valid", 32'(bus_if.valid), 32'd0);
      chk("t1_idle_gnt", 32'(bus_if.gnt), 32'd0);

      // All four requesting, ack every second granted cycle
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b1111, 1'b0, 1'b0);
      gaps = 0;
      for (int g = 0; g < 5; g++) begin
         cyc(4'b1111, 1'b0, 1'b0);
         if (bus_if.valid !== 1'b1) gaps++;
         else if (bus_if.hold_cnt == '0) order.push_back(int'(bus_if.sel));
         cyc((g == 4) ? 4'b0001 : 4'b1111, 1'b1, 1'b0);
         if (bus_if.valid !== 1'b1) gaps++;
      end
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t2_gaps", 32'(gaps), 32'd0);
      chk("t2_count", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         chk("t2_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(exp_order[i]));
      chk("t2_end_valid", 32'(bus_if.valid), 32'd0);

      // Withdrawal to idle, then withdrawal with back-to-back handoff
      cyc(4'b0100, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t3_gnt", 32'(bus_if.gnt), 32'h4);
      chk("t3_sel", 32'(bus_if.sel), 32'd2);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t3_wd_valid", 32'(bus_if.valid), 32'd0);
      chk("t3_wd_sel_held", 32'(bus_if.sel), 32'd2);
      chk("t3_wd_terr", 32'(bus_if.timeout_err), 32'd0);
      cyc(4'b0100, 1'b0, 1'b0);
      cyc(4'b0001, 1'b0, 1'b0);
      chk("t3b_gnt", 32'(bus_if.gnt), 32'h4);
      cyc(4'b0001, 1'b0, 1'b0);
      chk("t3b_handoff_gnt", 32'(bus_if.gnt), 32'h1);
      chk("t3b_handoff_terr", 32'(bus_if.timeout_err), 32'd0);
      cyc(4'b0000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t3b_idle", 32'(bus_if.valid), 32'd0);

      // Timeout revoke with no ack
      maxh = 0; pulses = 0; revoke_idle = 0;
      for (int i = 0; i < 20; i++) begin
         cyc((i < 18) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
         if (bus_if.valid === 1'b1 && int'(bus_if.hold_cnt) > maxh) maxh = int'(bus_if.hold_cnt);
         if (bus_if.timeout_err === 1'b1) pulses++;
         if (bus_if.timeout_err === 1'b1 && bus_if.valid === 1'b0) revoke_idle++;
         if (i == 18) chk("t4_regrant", 32'(bus_if.gnt), 32'h4);
      end
      chk("t4_max_hold", 32'(maxh), 32'd15);
      chk("t4_pulses", 32'(pulses), 32'd1);
      chk("t4_revoke_idle", 32'(revoke_idle), 32'd1);

      // Ack on the last allowed cycle, then ack coinciding with withdrawal
      cyc(4'b1000, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) cyc(4'b1000, 1'b0, 1'b0);
      cyc(4'b1000, 1'b1, 1'b0);
      chk("t5_hold15", 32'(bus_if.hold_cnt), 32'd15);
      chk("t5_gnt", 32'(bus_if.gnt), 32'h8);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t5_no_terr", 32'(bus_if.timeout_err), 32'd0);
      chk("t5_idle", 32'(bus_if.valid), 32'd0);
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);
      chk("t5b_gnt", 32'(bus_if.gnt), 32'h2);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t5b_idle", 32'(bus_if.valid), 32'd0);
      chk("t5b_terr", 32'(bus_if.timeout_err), 32'd0);

      // Reset while busy, pointer returns to 0
      cyc(4'b1000, 1'b0, 1'b0);
      cyc(4'b1000, 1'b0, 1'b1);
      chk("t6_gnt", 32'(bus_if.gnt), 32'h8);
      chk("t6_sel", 32'(bus_if.sel), 32'd3);
      cyc(4'b1010, 1'b0, 1'b0);
      chk("t6_rst_gnt", 32'(bus_if.gnt), 32'd0);
      chk("t6_rst_sel", 32'(bus_if.sel), 32'd0);
      chk("t6_rst_terr", 32'(bus_if.timeout_err), 32'd0);
      cyc(4'b0000, 1'b1, 1'b0);
      chk("t6_ptr0_gnt", 32'(bus_if.gnt), 32'h2);
      chk("t6_ptr0_sel", 32'(bus_if.sel), 32'd1);

      // ack while idle has no effect
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t7_idle_ack", 32'(bus_if.valid), 32'd0);
      cyc(4'b0000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
